pe_spad_wbuf: RTL and testbench
===============================

Name: pe_spad_wbuf

Overview:
- Per-PE scratchpad buffer directly downstream of the write-enable shift register (`sftreg`).
- Captures one data word on each delayed write-enable pulse (`o_we` from `sftreg`) into a circular register-file scratchpad.
- Serves words to the PE MAC datapath over a valid/ready read port.
- Supports row-stationary reuse: the read pointer can be rewound to the oldest retained entry, and entries are only freed by explicit pop.

Parameters:
- DATA_W, 16, width of one scratchpad word (ifmap/filter element)
- DEPTH, 12, number of entries; any integer ≥2, not necessarily a power of 2
- CNT_W, 4, width of occupancy/pointer fields; must satisfy 2^CNT_W > DEPTH

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_we  in  1  write strobe (driven by the delayed `o_we` from `sftreg`); no backpressure
- i_wdata  in  DATA_W  write data, sampled when i_we=1
- o_full  out  1  occupancy == DEPTH
- o_empty  out  1  occupancy == 0
- o_count  out  CNT_W  occupancy (entries written, not yet popped)
- o_overflow  out  1  sticky: a write arrived while full
- o_rd_valid  out  1  unread entry available at read pointer
- o_rd_data  out  DATA_W  word at read pointer
- i_rd_ready  in  1  consumer accepts o_rd_data this cycle
- i_rewind  in  1  set read pointer back to head (oldest retained entry)
- i_pop  in  1  free the oldest entry (advance head)

Behaviour:
- Reset is synchronous and active-high; clock and reset ports are i_clk / i_rst.
- Reset state (i_rst=1 at a rising edge): wr_ptr = head = rd_ptr = 0, count = 0, o_overflow = 0.
  - Reset outputs: o_empty=1, o_full=0, o_rd_valid=0, o_count=0.
  - Memory contents need not be cleared. Reset mid-operation discards all entries.
- Pointers: wr_ptr, head, rd_ptr each range 0..DEPTH-1 and wrap DEPTH-1 → 0. They are not power-of-2 masked.
- Unread counter ucnt = number of entries between rd_ptr and wr_ptr (0..count).
- Write: if i_we=1 and count<DEPTH, then mem[wr_ptr] ← i_wdata, wr_ptr advances, count+1, ucnt+1.
  - If i_we=1 and count==DEPTH, the write is dropped, pointers are unchanged, and o_overflow ← 1 (held until reset).
- Read: o_rd_valid = (ucnt != 0), combinational from registered state.
  - o_rd_data = mem[rd_ptr], combinational (fall-through, zero-cycle read latency).
  - Handshake: when o_rd_valid & i_rd_ready, rd_ptr advances and ucnt−1.
  - o_rd_data is X/don't-care when o_rd_valid=0.
- Write-to-read latency: a word written at edge N is visible with o_rd_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Pop: if i_pop=1 and count>0, head advances and count−1.
  - If rd_ptr == head (oldest entry not yet read), rd_ptr also advances and ucnt−1, so rd_ptr never lags head.
  - Pop when empty is ignored.
- Rewind: i_rewind=1 sets rd_ptr ← head (post-pop value if i_pop is also asserted) and ucnt ← count (post-update value). The read handshake in the same cycle is ignored; rewind wins.
- Simultaneous events in one cycle:
  - Write and pop both apply; a write while full is still dropped even if pop is asserted in the same cycle.
  - Write and read both apply (ucnt unchanged).
  - Pop and read where rd_ptr==head: rd_ptr advances once, not twice.
- o_full, o_empty, and o_count are registered-state derived, with no combinational path from inputs.

Test Plan:
- Reset, then 3 writes (i_wdata = 0x0011, 0x0022, 0x0033, one per cycle), i_rd_ready=0 → o_count=3, o_rd_valid=1 one cycle after the first write, o_rd_data=0x0011.
- i_rd_ready=1 for 3 cycles → data 0x0011, 0x0022, 0x0033 in order, then o_rd_valid=0 with o_count still 3. Then i_rewind pulse → o_rd_valid=1, o_rd_data=0x0011 again.
- Fill to DEPTH=12 (values 1..12) → o_full=1. A 13th write (0xBEEF) → dropped, o_overflow=1 sticky, and a subsequent full readout shows 1..12 with no 0xBEEF.
- Wrap-around: with 10 entries, pop 8 then write 6 (wr_ptr wraps past 11) → o_count=8. After a rewind, the read sequence is entries 9,10 followed by the 6 new words in order.
- Simultaneous: with count=2 and rd_ptr==head, assert i_pop, i_rd_ready, and i_we together → count stays 2, rd_ptr advances exactly one, and the next o_rd_data is the second old entry.
- Reset mid-stream (5 entries, 2 read) with i_rst=1 for one cycle → o_count=0, o_empty=1, o_rd_valid=0, o_overflow=0. The next write reads back correctly.

Source files
------------

// File: rtl/pe_spad_wbuf.sv
// pe_spad_wbuf: per-PE circular scratchpad fed by the delayed write strobe of
// the write-enable shift register.
// Words are served to the MAC datapath through a fall-through valid/ready port.
// Entries stay retained after being read until they are explicitly popped.
// This allows the read pointer to be rewound to the oldest retained entry for
// row-stationary reuse.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_we, i_wdata         write strobe and data (no backpressure)
//   o_full, o_empty       occupancy == DEPTH / occupancy == 0
//   o_count               occupancy (written, not yet popped)
//   o_overflow            sticky: write arrived while full
//   o_rd_valid, o_rd_data unread word at read pointer (zero-latency)
//   i_rd_ready            consumer accepts o_rd_data this cycle
//   i_rewind              read pointer back to head
//   i_pop                 free the oldest entry

module pe_spad_wbuf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_rd_ready,
    input  logic              i_rewind,
    input  logic              i_pop
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] head_q,   head_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] ucnt_q,   ucnt_d;
    logic             overflow_q, overflow_d;

    logic do_wr, do_rd, do_pop, pop_drags_rd, rd_adv;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
        return (p == LAST_C) ? '0 : p + CNT_W'(1);
    endfunction

    always_comb begin
        do_wr  = i_we && (count_q != DEPTH_C);
        do_rd  = (ucnt_q != '0) && i_rd_ready;
        do_pop = i_pop && (count_q != '0);
        // The oldest entry is still unread only when every retained entry is unread.
        // Comparing pointers alone is ambiguous when the buffer is full and fully read.
        pop_drags_rd = do_pop && (rd_ptr_q == head_q) && (ucnt_q == count_q);
        // A read and a dragging pop in the same cycle advance rd_ptr only once.
        rd_adv = do_rd || pop_drags_rd;

        wr_ptr_d   = do_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        head_d     = do_pop ? ptr_inc(head_q)   : head_q;
        count_d    = count_q + CNT_W'(do_wr) - CNT_W'(do_pop);
        overflow_d = overflow_q || (i_we && !do_wr);

        if (i_rewind) begin
            rd_ptr_d = head_d;
            ucnt_d   = count_d;
        end else begin
            rd_ptr_d = rd_adv ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            ucnt_d   = ucnt_q + CNT_W'(do_wr) - CNT_W'(rd_adv);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            head_q     <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ucnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            head_q     <= head_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ucnt_q     <= ucnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy state alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_wr) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_comb begin
        o_full     = (count_q == DEPTH_C);
        o_empty    = (count_q == '0);
        o_count    = count_q;
        o_overflow = overflow_q;
        o_rd_valid = (ucnt_q != '0);
        o_rd_data  = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_pe_spad_wbuf.sv
module tb_pe_spad_wbuf;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 12;
    localparam int CNT_W  = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_we = 1'b0;
    logic [DATA_W-1:0] i_wdata = '0;
    logic              o_full, o_empty, o_overflow, o_rd_valid;
    logic [CNT_W-1:0]  o_count;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_rd_ready = 1'b0;
    logic              i_rewind = 1'b0;
    logic              i_pop = 1'b0;

    pe_spad_wbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (i_we),
        .i_wdata    (i_wdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .i_rd_ready (i_rd_ready),
        .i_rewind   (i_rewind),
        .i_pop      (i_pop)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: retained entries in age order, plus index of next unread one.
    logic [DATA_W-1:0] ret_q[$];
    int                rd_idx = 0;
    logic              ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        int n;
        n = ret_q.size();
        chk({tag, ".count"}, 32'(o_count), 32'(n));
        chk({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(o_full), 32'(n == DEPTH));
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(ovf));
        chk({tag, ".valid"}, 32'(o_rd_valid), 32'(rd_idx < n));
        if (rd_idx < n) chk({tag, ".data"}, 32'(o_rd_data), 32'(ret_q[rd_idx]));
    endtask

    task automatic model_wr(input logic [DATA_W-1:0] d);
        if (ret_q.size() < DEPTH) ret_q.push_back(d);
        else ovf = 1'b1;
    endtask

    task automatic model_pop();
        if (ret_q.size() > 0) begin
            void'(ret_q.pop_front());
            if (rd_idx > 0) rd_idx--;
        end
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        i_we = 1'b1;
        i_wdata = d;
        model_wr(d);
        tick();
        i_we = 1'b0;
    endtask

    task automatic rd(input string tag);
        chk({tag, ".rv"}, 32'(o_rd_valid), 32'd1);
        chk({tag, ".rd"}, 32'(o_rd_data), 32'(ret_q[rd_idx]));
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
        rd_idx++;
    endtask

    task automatic pop();
        i_pop = 1'b1;
        model_pop();
        tick();
        i_pop = 1'b0;
    endtask

    task automatic rewind();
        i_rewind = 1'b1;
        tick();
        i_rewind = 1'b0;
        rd_idx = 0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        ret_q.delete();
        rd_idx = 0;
        ovf = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_state("reset");

        // Pop when empty is ignored
        pop();
        check_state("pop_empty");

        // Three writes; valid the cycle after the first write
        wr(16'h0011);
        check_state("wr1");
        wr(16'h0022);
        wr(16'h0033);
        check_state("wr3");
        chk("wr3.head_data", 32'(o_rd_data), 32'h0011);

        // Drain without popping, then rewind
        for (int i = 0; i < 3; i++) rd("drain");
        check_state("drained");
        rewind();
        check_state("rewind");
        chk("rewind.data", 32'(o_rd_data), 32'h0011);

        // Fill, overflow, full readout
        do_reset();
        for (int i = 1; i <= DEPTH; i++) wr(DATA_W'(i));
        check_state("full");
        wr(16'hBEEF);
        check_state("overflow");
        for (int i = 0; i < DEPTH; i++) rd("full_rd");
        check_state("full_drained");
        wr(16'hBEEF);
        check_state("ovf_sticky");

        // Wrap-around: 10 entries, pop 8, write 6
        do_reset();
        for (int i = 1; i <= 10; i++) wr(DATA_W'(16'h0100 + i));
        for (int i = 0; i < 8; i++) pop();
        for (int i = 1; i <= 6; i++) wr(DATA_W'(16'h0200 + i));
        check_state("wrap");
        chk("wrap.count", 32'(o_count), 32'd8);
        rewind();
        chk("wrap.first", 32'(o_rd_data), 32'h0109);
        for (int i = 0; i < 8; i++) rd("wrap_rd");
        check_state("wrap_done");

        // Simultaneous pop + read + write with rd_ptr == head
        do_reset();
        wr(16'hA001);
        wr(16'hA002);
        check_state("sim_pre");
        chk("sim.rd", 32'(o_rd_data), 32'hA001);
        i_pop = 1'b1;
        i_rd_ready = 1'b1;
        i_we = 1'b1;
        i_wdata = 16'hA003;
        model_wr(16'hA003);
        rd_idx++;
        model_pop();
        tick();
        i_pop = 1'b0;
        i_rd_ready = 1'b0;
        i_we = 1'b0;
        check_state("sim_post");
        chk("sim.count", 32'(o_count), 32'd2);
        chk("sim.next", 32'(o_rd_data), 32'hA002);
        rd("sim_rd");
        rd("sim_rd");
        check_state("sim_done");

        // Reset mid-stream with overflow set: 5 entries, 2 read
        do_reset();
        for (int i = 0; i <= DEPTH; i++) wr(DATA_W'(16'h0300 + i));
        for (int i = 0; i < 7; i++) pop();
        rd("mid_rd");
        rd("mid_rd");
        check_state("mid_pre");
        do_reset();
        check_state("mid_reset");
        chk("mid_reset.ovf", 32'(o_overflow), 32'd0);
        wr(16'h5A5A);
        check_state("post_reset_wr");
        rd("post_reset_rd");
        check_state("post_reset_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
